// File: rtl/data_memory_hs.sv
// Byte-addressed data memory with a valid/ready request and response handshake.
// Loads and stores of 1, 2 or 4 bytes, with a fixed response latency.
package data_memory_hs_pkg;
  localparam logic [2:0] LB_SB = 3'b000;
  localparam logic [2:0] LH_SH = 3'b001;
  localparam logic [2:0] LW_SW = 3'b010;
  localparam logic [2:0] LBU   = 3'b100;
  localparam logic [2:0] LHU   = 3'b101;
endpackage

// state | meaning
// IDLE  | ready for a request; req_ready high while reset is released
// WAIT  | request taken, counting down the remaining latency
// RESP  | response presented, held until rsp_ready
module data_memory_hs
  import data_memory_hs_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);
  localparam int IDX_W = $clog2(DEPTH_BYTES);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH_BYTES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state;
  logic [2:0]       cnt;
  logic [7:0]       mem [DEPTH_BYTES];
  logic [2:0]       acc_size;
  logic             acc_err;
  logic             accept;
  logic             do_store;
  logic [ADDR_W:0]  end_addr;
  logic [IDX_W-1:0] idx0, idx1, idx2, idx3;
  logic [7:0]       b0, b1, b2, b3;
  logic [31:0]      load_data;

  assign req_ready = (state == IDLE) && reset;
  assign accept    = req_valid && req_ready;

  always_comb begin
    acc_size = 3'd0;
    case (req_op)
      LB_SB, LBU: acc_size = 3'd1;
      LH_SH, LHU: acc_size = 3'd2;
      LW_SW:      acc_size = 3'd4;
      default:    acc_size = 3'd0;
    endcase
  end

  // One extra bit so addresses near the top of the address space cannot wrap past the check.
  assign end_addr = {1'b0, req_addr} + {{(ADDR_W-2){1'b0}}, acc_size};

  assign acc_err = (acc_size == 3'd0)
                || (acc_size == 3'd2 && req_addr[0])
                || (acc_size == 3'd4 && req_addr[1:0] != 2'b00)
                || (end_addr > DEPTH_L)
                || (req_we && (req_op == LBU || req_op == LHU));

  assign idx0 = req_addr[IDX_W-1:0];
  assign idx1 = idx0 + IDX_W'(1);
  assign idx2 = idx0 + IDX_W'(2);
  assign idx3 = idx0 + IDX_W'(3);
  assign b0   = mem[idx0];
  assign b1   = mem[idx1];
  assign b2   = mem[idx2];
  assign b3   = mem[idx3];

  always_comb begin
    load_data = 32'd0;
    case (req_op)
      LB_SB:   load_data = {{24{b0[7]}}, b0};
      LBU:     load_data = {24'd0, b0};
      LH_SH:   load_data = {{16{b1[7]}}, b1, b0};
      LHU:     load_data = {16'd0, b1, b0};
      LW_SW:   load_data = {b3, b2, b1, b0};
      default: load_data = 32'd0;
    endcase
  end

  assign do_store = accept && req_we && !acc_err;

  // Storage is never reset; a store commits on its accept edge regardless of later resets.
  always_ff @(posedge clock) begin
    if (do_store) begin
      mem[idx0] <= req_wdata[7:0];
      if (acc_size != 3'd1) begin
        mem[idx1] <= req_wdata[15:8];
      end
      if (acc_size == 3'd4) begin
        mem[idx2] <= req_wdata[23:16];
        mem[idx3] <= req_wdata[31:24];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rsp_rdata <= (req_we || acc_err) ? 32'd0 : load_data;
            rsp_err   <= acc_err;
            if (LATENCY == 1) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= 3'(LATENCY - 2);
            end
          end
        end
        WAIT: begin
          if (cnt == 3'd0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
